hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Pipeline sequencer paired with the EXE-stage forwarding unit. Handles hazards that forwarding cannot
//  resolve: load-use (stall + bubble), taken branch resolved in EXE (flush), and multi-cycle mult/div
//  occupancy (countdown FSM, stalls dependent HI/LO users). Drives PC/IF-ID write enables, flush/bubble
//  controls and a saturating stall-cycle performance counter.
// PARAMETERS
//  REG_ADDRESS_LENGTH  5   register address width (matches `REG_ADDRESS_LENGTH)
//  MD_LATENCY          8   cycles a mult/div occupies the unit after MD_Start (>=2)
//  CNT_W               4   width of MD countdown; must hold MD_LATENCY
//  PERF_W              16  width of stall-cycle counter
// PORTS
//  clk            in   1        clock, all state updates on rising edge
//  rst_n          in   1        synchronous active-low reset
//  ID_Rs          in   RAL      source reg A of instruction in ID
//  ID_Rt          in   RAL      source reg B of instruction in ID
//  ID_UsesRt      in   1        ID instruction reads Rt as a source
//  ID_MultDiv     in   1        ID instruction is mult/div (starts multi-cycle op)
//  ID_ReadsHiLo   in   1        ID instruction is mfhi/mflo
//  EXE_MemRead    in   1        instruction in EXE is a load
//  EXE_Rt         in   RAL      load destination in EXE
//  EXE_BranchTaken in  1        branch/jump in EXE resolved taken
//  PC_Write       out  1        PC update enable
//  IFID_Write     out  1        IF/ID register write enable
//  IFID_Flush     out  1        clear IF/ID to NOP
//  IDEXE_Bubble   out  1        inject NOP into ID/EXE
//  MD_Start       out  1        one-cycle launch pulse to mult/div unit
//  MD_Busy        out  1        mult/div unit occupied (state == MD_BUSY)
//  Stall_Count    out  PERF_W   saturating count of cycles with PC_Write==0
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): state=IDLE, md_cnt=0, Stall_Count=0. Control outputs are combinational
//   from state + inputs; while rst_n==0 they are forced to PC_Write=1, IFID_Write=1, others 0.
//  Hazard terms (combinational):
//   load_use = EXE_MemRead && EXE_Rt!=0 && (EXE_Rt==ID_Rs || (ID_UsesRt && EXE_Rt==ID_Rt))
//   md_dep   = (state==MD_BUSY) && (ID_ReadsHiLo || ID_MultDiv)
//   stall    = !EXE_BranchTaken && (load_use || md_dep)
//  Priority: EXE_BranchTaken > stall > MD launch.
//   Branch: IFID_Flush=1, IDEXE_Bubble=1, PC_Write=1, IFID_Write=1; any load_use/md_dep that cycle
//    ignored (ID instr is wrong-path); ID_MultDiv ignored, no MD_Start.
//   Stall: PC_Write=0, IFID_Write=0, IDEXE_Bubble=1, IFID_Flush=0.
//   Otherwise: PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEXE_Bubble=0.
//  Load-use stall lasts exactly 1 cycle (load advances to MEM; forwarding then covers it).
//  FSM (registered):
//   IDLE: MD_Start = ID_MultDiv && !EXE_BranchTaken && !load_use. On MD_Start -> MD_BUSY, md_cnt=MD_LATENCY-1.
//   MD_BUSY: md_cnt decrements each cycle; independent instructions flow unstalled. Branch flush does NOT
//    abort the in-flight op. When md_cnt==1 -> IDLE next edge (md_cnt=0). Busy for MD_LATENCY-1 cycles after
//    the MD_Start cycle; a dependent op stalled in ID proceeds (and may launch) in the first IDLE cycle.
//   No back-to-back MD_Start; MD_Start never asserted in MD_BUSY.
//  Stall_Count: +1 on each posedge where PC_Write==0; saturates at 2^PERF_W-1 (no wrap).
//  Reset mid-MD_BUSY: returns to IDLE next edge, md_cnt cleared; Stall_Count cleared.
// TESTING
//  1 lw r3 in EXE (EXE_MemRead=1,EXE_Rt=3), ID_Rs=3 -> 1 cycle PC_Write=0,IDEXE_Bubble=1; next cycle clear; Stall_Count=1.
//  2 Same but EXE_Rt=0, or ID_Rt=3 with ID_UsesRt=0 -> no stall.
//  3 load_use and EXE_BranchTaken together -> IFID_Flush=1,IDEXE_Bubble=1,PC_Write=1; Stall_Count unchanged.
//  4 ID_MultDiv=1 in IDLE, MD_LATENCY=8 -> MD_Start 1 cycle, MD_Busy high 7 cycles; ID_ReadsHiLo held ->
//    stalled 7 cycles, released first IDLE cycle; Stall_Count=7.
//  5 Branch taken during MD_BUSY -> flush only, md_cnt keeps counting; rst_n=0 mid-busy -> IDLE, MD_Busy=0 next edge.
//  6 PERF_W=4, hold load_use-style stalls 20 cycles -> Stall_Count stops at 15.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline sequencer that works alongside the EXE-stage forwarding unit.
//   It covers the hazards forwarding cannot resolve:
//     - load-use: one-cycle stall of PC and IF/ID, with a bubble into ID/EXE
//     - taken branch resolved in EXE: flush IF/ID and bubble ID/EXE
//     - mult/div occupancy: a countdown FSM that stalls dependent HI/LO users
//   It also keeps a saturating count of cycles in which the PC was held.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   ID_Rs, ID_Rt     source registers of the instruction in ID
//   ID_UsesRt        the ID instruction reads Rt
//   ID_MultDiv       the ID instruction is a mult/div
//   ID_ReadsHiLo     the ID instruction is mfhi/mflo
//   EXE_MemRead      the EXE instruction is a load
//   EXE_Rt           destination register of the load in EXE
//   EXE_BranchTaken  the EXE branch/jump resolved taken
//   PC_Write         PC update enable (combinational)
//   IFID_Write       IF/ID write enable (combinational)
//   IFID_Flush       clear IF/ID to NOP (combinational)
//   IDEXE_Bubble     inject NOP into ID/EXE (combinational)
//   MD_Start         one-cycle launch pulse to the mult/div unit (combinational)
//   MD_Busy          mult/div unit occupied (combinational from state)
//   Stall_Count      registered, saturating count of cycles with PC_Write==0
module hazard_control_unit #(
  parameter int unsigned REG_ADDRESS_LENGTH = 5,
  parameter int unsigned MD_LATENCY         = 8,
  parameter int unsigned CNT_W              = 4,
  parameter int unsigned PERF_W             = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REG_ADDRESS_LENGTH-1:0] ID_Rs,
  input  logic [REG_ADDRESS_LENGTH-1:0] ID_Rt,
  input  logic                          ID_UsesRt,
  input  logic                          ID_MultDiv,
  input  logic                          ID_ReadsHiLo,
  input  logic                          EXE_MemRead,
  input  logic [REG_ADDRESS_LENGTH-1:0] EXE_Rt,
  input  logic                          EXE_BranchTaken,
  output logic                          PC_Write,
  output logic                          IFID_Write,
  output logic                          IFID_Flush,
  output logic                          IDEXE_Bubble,
  output logic                          MD_Start,
  output logic                          MD_Busy,
  output logic [PERF_W-1:0]             Stall_Count
);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic md_dep;
  logic stall;

  // Hazard detection; a load into r0 never creates a dependency.
  always_comb begin
    load_use = EXE_MemRead && (EXE_Rt != '0) &&
               ((EXE_Rt == ID_Rs) || (ID_UsesRt && (EXE_Rt == ID_Rt)));
    md_dep   = (state_q == MD_BUSY) && (ID_ReadsHiLo || ID_MultDiv);
    stall    = !EXE_BranchTaken && (load_use || md_dep);
  end

  // State register, mult/div countdown and performance counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and control outputs; branch beats stall beats MD launch.
  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEXE_Bubble = 1'b0;
    MD_Start     = 1'b0;
    MD_Busy      = (state_q == MD_BUSY);

    if (EXE_BranchTaken) begin
      IFID_Flush   = 1'b1;
      IDEXE_Bubble = 1'b1;
    end else if (stall) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEXE_Bubble = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        // A load-use stall holds the mult/div in ID, so launch waits for it.
        MD_Start = ID_MultDiv && !EXE_BranchTaken && !load_use;
        if (MD_Start) begin
          state_d  = MD_BUSY;
          md_cnt_d = CNT_W'(MD_LATENCY - 1);
        end
      end
      MD_BUSY: begin
        // Flushes do not abort the in-flight op; the countdown always runs.
        if (md_cnt_q == CNT_W'(1)) begin
          state_d  = IDLE;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        md_cnt_d = '0;
      end
    endcase

    if (!rst_n) begin
      PC_Write     = 1'b1;
      IFID_Write   = 1'b1;
      IFID_Flush   = 1'b0;
      IDEXE_Bubble = 1'b0;
      MD_Start     = 1'b0;
      MD_Busy      = 1'b0;
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: load-use, branch flush, mult/div
// occupancy, reset in the middle of a mult/div, and counter saturation on a
// second instance built with a 4-bit counter.
module tb_hazard_control_unit;

  localparam int unsigned RAL = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [RAL-1:0] ID_Rs, ID_Rt, EXE_Rt;
  logic           ID_UsesRt, ID_MultDiv, ID_ReadsHiLo;
  logic           EXE_MemRead, EXE_BranchTaken;

  logic        PC_Write, IFID_Write, IFID_Flush, IDEXE_Bubble, MD_Start, MD_Busy;
  logic [15:0] Stall_Count;

  logic        s_PC_Write, s_IFID_Write, s_IFID_Flush, s_IDEXE_Bubble, s_MD_Start, s_MD_Busy;
  logic [3:0]  s_Stall_Count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDRESS_LENGTH(RAL), .MD_LATENCY(8), .CNT_W(4), .PERF_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_MultDiv(ID_MultDiv),
    .ID_ReadsHiLo(ID_ReadsHiLo), .EXE_MemRead(EXE_MemRead), .EXE_Rt(EXE_Rt),
    .EXE_BranchTaken(EXE_BranchTaken),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEXE_Bubble(IDEXE_Bubble), .MD_Start(MD_Start), .MD_Busy(MD_Busy),
    .Stall_Count(Stall_Count)
  );

  hazard_control_unit #(.REG_ADDRESS_LENGTH(RAL), .MD_LATENCY(8), .CNT_W(4), .PERF_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_MultDiv(ID_MultDiv),
    .ID_ReadsHiLo(ID_ReadsHiLo), .EXE_MemRead(EXE_MemRead), .EXE_Rt(EXE_Rt),
    .EXE_BranchTaken(EXE_BranchTaken),
    .PC_Write(s_PC_Write), .IFID_Write(s_IFID_Write), .IFID_Flush(s_IFID_Flush),
    .IDEXE_Bubble(s_IDEXE_Bubble), .MD_Start(s_MD_Start), .MD_Busy(s_MD_Busy),
    .Stall_Count(s_Stall_Count)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs = '0; ID_Rt = '0; EXE_Rt = '0;
    ID_UsesRt = 1'b0; ID_MultDiv = 1'b0; ID_ReadsHiLo = 1'b0;
    EXE_MemRead = 1'b0; EXE_BranchTaken = 1'b0;
  endtask

  initial begin
    // Reset with a load-use and a mult/div present: outputs must be forced.
    rst_n = 1'b0;
    clear_inputs();
    EXE_MemRead = 1'b1; EXE_Rt = 5'd3; ID_Rs = 5'd3; ID_MultDiv = 1'b1;
    step(); step();
    chk1("rst_pc_write", PC_Write, 1'b1);
    chk1("rst_ifid_write", IFID_Write, 1'b1);
    chk1("rst_bubble", IDEXE_Bubble, 1'b0);
    chk1("rst_md_start", MD_Start, 1'b0);
    chk1("rst_md_busy", MD_Busy, 1'b0);
    chk16("rst_stall_count", Stall_Count, 16'd0);
    clear_inputs();
    rst_n = 1'b1;
    #1;
    chk1("idle_flush", IFID_Flush, 1'b0);
    chk1("idle_pc_write", PC_Write, 1'b1);

    // 1: load-use on Rs stalls exactly one cycle.
    EXE_MemRead = 1'b1; EXE_Rt = 5'd3; ID_Rs = 5'd3;
    #1;
    chk1("lu_pc_write", PC_Write, 1'b0);
    chk1("lu_ifid_write", IFID_Write, 1'b0);
    chk1("lu_bubble", IDEXE_Bubble, 1'b1);
    chk1("lu_flush", IFID_Flush, 1'b0);
    step();
    clear_inputs();
    ID_Rs = 5'd3;
    #1;
    chk1("lu_release_pc", PC_Write, 1'b1);
    chk1("lu_release_bubble", IDEXE_Bubble, 1'b0);
    chk16("lu_count", Stall_Count, 16'd1);

    // 2: r0 destination and unused Rt do not stall; used Rt does.
    EXE_MemRead = 1'b1; EXE_Rt = 5'd0; ID_Rs = 5'd0;
    #1;
    chk1("r0_no_stall", PC_Write, 1'b1);
    EXE_Rt = 5'd3; ID_Rs = 5'd5; ID_Rt = 5'd3; ID_UsesRt = 1'b0;
    #1;
    chk1("rt_unused_no_stall", PC_Write, 1'b1);
    ID_UsesRt = 1'b1;
    #1;
    chk1("rt_used_stall", PC_Write, 1'b0);
    chk1("rt_used_bubble", IDEXE_Bubble, 1'b1);
    step();
    chk16("rt_count", Stall_Count, 16'd2);

    // 3: branch overrides load-use and suppresses MD launch.
    EXE_BranchTaken = 1'b1; ID_MultDiv = 1'b1;
    #1;
    chk1("br_flush", IFID_Flush, 1'b1);
    chk1("br_bubble", IDEXE_Bubble, 1'b1);
    chk1("br_pc_write", PC_Write, 1'b1);
    chk1("br_ifid_write", IFID_Write, 1'b1);
    chk1("br_md_start", MD_Start, 1'b0);
    step();
    chk16("br_count", Stall_Count, 16'd2);
    chk1("br_no_md_busy", MD_Busy, 1'b0);

    // 4: mult/div launch, then mfhi stalled for 7 busy cycles.
    clear_inputs();
    ID_MultDiv = 1'b1;
    #1;
    chk1("md_start", MD_Start, 1'b1);
    chk1("md_start_pc", PC_Write, 1'b1);
    chk1("md_start_not_busy", MD_Busy, 1'b0);
    step();
    ID_MultDiv = 1'b0; ID_ReadsHiLo = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk1($sformatf("md_busy_%0d", i), MD_Busy, 1'b1);
      chk1($sformatf("md_dep_stall_%0d", i), PC_Write, 1'b0);
      chk1($sformatf("md_no_restart_%0d", i), MD_Start, 1'b0);
      step();
    end
    chk1("md_idle_again", MD_Busy, 1'b0);
    chk1("md_dep_released", PC_Write, 1'b1);
    chk16("md_count", Stall_Count, 16'd9);
    // Dependent mult/div launches in the first idle cycle.
    ID_ReadsHiLo = 1'b0; ID_MultDiv = 1'b1;
    #1;
    chk1("md_relaunch", MD_Start, 1'b1);
    step();

    // 5: independent flow during busy, branch does not abort countdown.
    ID_MultDiv = 1'b0;
    #1;
    chk1("md_indep_busy", MD_Busy, 1'b1);
    chk1("md_indep_flow", PC_Write, 1'b1);
    step();
    step();
    EXE_BranchTaken = 1'b1; ID_ReadsHiLo = 1'b1;
    #1;
    chk1("md_br_flush", IFID_Flush, 1'b1);
    chk1("md_br_pc", PC_Write, 1'b1);
    chk1("md_br_busy", MD_Busy, 1'b1);
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1($sformatf("md_br_tail_%0d", i), MD_Busy, 1'b1);
      step();
    end
    chk1("md_br_done", MD_Busy, 1'b0);
    chk16("md_br_count", Stall_Count, 16'd9);

    // 5b: reset in the middle of a busy window.
    ID_MultDiv = 1'b1;
    step();
    ID_MultDiv = 1'b0;
    step();
    chk1("rst_mid_busy_pre", MD_Busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_forced", MD_Busy, 1'b0);
    step();
    rst_n = 1'b1;
    ID_ReadsHiLo = 1'b1;
    #1;
    chk1("rst_mid_idle", MD_Busy, 1'b0);
    chk1("rst_mid_no_dep", PC_Write, 1'b1);
    chk16("rst_mid_count", Stall_Count, 16'd0);
    chk16("rst_mid_sat_count", 16'(s_Stall_Count), 16'd0);

    // 6: 20 stall cycles saturate the 4-bit counter at 15.
    clear_inputs();
    EXE_MemRead = 1'b1; EXE_Rt = 5'd7; ID_Rs = 5'd7;
    for (int i = 0; i < 20; i++) step();
    chk16("sat_wide_count", Stall_Count, 16'd20);
    chk16("sat_narrow_count", 16'(s_Stall_Count), 16'd15);
    clear_inputs();
    step();
    chk16("sat_hold", 16'(s_Stall_Count), 16'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
